axi4_bch_drop_sender: RTL and testbench



---
 rtl/axi4_bch_drop_sender.sv | 159 +++++++++++++++
 tb/tb_axi4_bch_drop_sender.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_bch_drop_sender.sv
// Write-response sender for the RAB slave side: injects local B responses for dropped AW
// transactions once their W bursts complete, and shares the slave B channel with forwarded master responses.
module axi4_bch_drop_sender #(
  parameter int C_AXI_ID_WIDTH   = 10,
  parameter int C_AXI_USER_WIDTH = 4,
  parameter int DROP_FIFO_DEPTH  = 4,
  parameter int ORDER_FIFO_DEPTH = 8,
  parameter int C_CNT_WIDTH      = 16
) (
  input  logic                        axi4_aclk,
  input  logic                        axi4_arstn,
  input  logic                        trans_valid,
  input  logic                        trans_drop,
  input  logic [C_AXI_ID_WIDTH-1:0]   trans_id,
  input  logic [1:0]                  trans_resp,
  output logic                        trans_ready,
  input  logic                        s_axi4_wvalid,
  input  logic                        s_axi4_wready,
  input  logic                        s_axi4_wlast,
  output logic [C_AXI_ID_WIDTH-1:0]   s_axi4_bid,
  output logic [1:0]                  s_axi4_bresp,
  output logic [C_AXI_USER_WIDTH-1:0] s_axi4_buser,
  output logic                        s_axi4_bvalid,
  input  logic                        s_axi4_bready,
  input  logic [C_AXI_ID_WIDTH-1:0]   m_axi4_bid,
  input  logic [1:0]                  m_axi4_bresp,
  input  logic [C_AXI_USER_WIDTH-1:0] m_axi4_buser,
  input  logic                        m_axi4_bvalid,
  output logic                        m_axi4_bready,
  output logic [C_CNT_WIDTH-1:0]      drop_cnt,
  output logic                        protocol_err
);

  // state    | meaning
  // ARB_FREE | no B handshake in flight, grant chosen round-robin each cycle
  // ARB_LINJ | injected response presented without bready, grant held on inject
  // ARB_LMST | forwarded response presented without bready, grant held on master
  typedef enum logic [1:0] {ARB_FREE, ARB_LINJ, ARB_LMST} arb_state_e;

  localparam int OAW = $clog2(ORDER_FIFO_DEPTH);
  localparam int DAW = $clog2(DROP_FIFO_DEPTH);
  localparam int DW  = C_AXI_ID_WIDTH + 2;

  localparam logic [OAW:0]         ORD_ONE = 1;
  localparam logic [DAW:0]         DRP_ONE = 1;
  localparam logic [C_CNT_WIDTH-1:0] CNT_ONE = 1;

  logic [ORDER_FIFO_DEPTH-1:0] ord_mem_q;
  logic [OAW:0]                ord_wr_q, ord_wr_d, ord_rd_q, ord_rd_d;
  logic [DW-1:0]               drop_mem_q [DROP_FIFO_DEPTH];
  logic [DAW:0]                drop_wr_q, drop_wr_d, drop_rd_q, drop_rd_d;
  logic [DAW:0]                wl_cnt_q, wl_cnt_d;
  logic [C_CNT_WIDTH-1:0]      drop_cnt_q, drop_cnt_d;
  logic                        perr_q, perr_d;
  logic                        last_inj_q, last_inj_d;
  arb_state_e                  arb_q, arb_d;

  logic ord_empty, ord_full, drop_empty, drop_full;
  logic trans_hs, wl_hs, bypass, ord_push, ord_pop, drop_push, wl_drop;
  logic inj_req, gnt_inj, inj_hs, fwd_hs;
  logic [DW-1:0] drop_head;

  assign ord_empty  = (ord_wr_q == ord_rd_q);
  assign ord_full   = (ord_wr_q[OAW] != ord_rd_q[OAW]) &&
                      (ord_wr_q[OAW-1:0] == ord_rd_q[OAW-1:0]);
  assign drop_empty = (drop_wr_q == drop_rd_q);
  assign drop_full  = (drop_wr_q[DAW] != drop_rd_q[DAW]) &&
                      (drop_wr_q[DAW-1:0] == drop_rd_q[DAW-1:0]);
  assign drop_head  = drop_mem_q[drop_rd_q[DAW-1:0]];

  assign trans_ready = ~ord_full & ~drop_full;
  assign trans_hs    = trans_valid & trans_ready;
  assign wl_hs       = s_axi4_wvalid & s_axi4_wready & s_axi4_wlast;

  // A W last arriving with an empty order FIFO consumes a same-cycle decision directly.
  assign bypass    = wl_hs & ord_empty & trans_hs;
  assign ord_pop   = wl_hs & ~ord_empty;
  assign ord_push  = trans_hs & ~bypass;
  assign drop_push = trans_hs & trans_drop;
  assign wl_drop   = bypass ? trans_drop : (ord_pop & ord_mem_q[ord_rd_q[OAW-1:0]]);

  assign inj_req = ~drop_empty & (wl_cnt_q != '0);

  always_comb begin
    arb_d         = ARB_FREE;
    gnt_inj       = 1'b0;
    s_axi4_bid    = m_axi4_bid;
    s_axi4_bresp  = m_axi4_bresp;
    s_axi4_buser  = m_axi4_buser;
    s_axi4_bvalid = m_axi4_bvalid;
    m_axi4_bready = s_axi4_bready;
    case (arb_q)
      ARB_FREE: gnt_inj = inj_req & (~m_axi4_bvalid | ~last_inj_q);
      ARB_LINJ: gnt_inj = 1'b1;
      ARB_LMST: gnt_inj = 1'b0;
      default:  gnt_inj = 1'b0;
    endcase
    if (gnt_inj) begin
      s_axi4_bid    = drop_head[DW-1:2];
      s_axi4_bresp  = drop_head[1:0];
      s_axi4_buser  = '0;
      s_axi4_bvalid = 1'b1;
      m_axi4_bready = 1'b0;
    end
    if (s_axi4_bvalid & ~s_axi4_bready) arb_d = gnt_inj ? ARB_LINJ : ARB_LMST;
  end

  assign inj_hs = gnt_inj & s_axi4_bready;
  assign fwd_hs = ~gnt_inj & m_axi4_bvalid & s_axi4_bready;

  always_comb begin
    ord_wr_d   = ord_push  ? ord_wr_q + ORD_ONE  : ord_wr_q;
    ord_rd_d   = ord_pop   ? ord_rd_q + ORD_ONE  : ord_rd_q;
    drop_wr_d  = drop_push ? drop_wr_q + DRP_ONE : drop_wr_q;
    drop_rd_d  = inj_hs    ? drop_rd_q + DRP_ONE : drop_rd_q;
    drop_cnt_d = inj_hs    ? drop_cnt_q + CNT_ONE : drop_cnt_q;
    wl_cnt_d   = wl_cnt_q;
    if (wl_drop & ~inj_hs)      wl_cnt_d = wl_cnt_q + DRP_ONE;
    else if (~wl_drop & inj_hs) wl_cnt_d = wl_cnt_q - DRP_ONE;
    perr_d     = perr_q | (wl_hs & ord_empty & ~trans_hs);
    last_inj_d = last_inj_q;
    if (inj_hs)      last_inj_d = 1'b1;
    else if (fwd_hs) last_inj_d = 1'b0;
  end

  always_ff @(posedge axi4_aclk or negedge axi4_arstn) begin
    if (!axi4_arstn) begin
      ord_wr_q   <= '0;
      ord_rd_q   <= '0;
      drop_wr_q  <= '0;
      drop_rd_q  <= '0;
      wl_cnt_q   <= '0;
      drop_cnt_q <= '0;
      perr_q     <= 1'b0;
      last_inj_q <= 1'b1;
      arb_q      <= ARB_FREE;
    end else begin
      ord_wr_q   <= ord_wr_d;
      ord_rd_q   <= ord_rd_d;
      drop_wr_q  <= drop_wr_d;
      drop_rd_q  <= drop_rd_d;
      wl_cnt_q   <= wl_cnt_d;
      drop_cnt_q <= drop_cnt_d;
      perr_q     <= perr_d;
      last_inj_q <= last_inj_d;
      arb_q      <= arb_d;
    end
  end

  // Storage needs no reset: occupancy is tracked entirely by the pointers.
  always_ff @(posedge axi4_aclk) begin
    if (ord_push)  ord_mem_q[ord_wr_q[OAW-1:0]] <= trans_drop;
    if (drop_push) drop_mem_q[drop_wr_q[DAW-1:0]] <= {trans_id, trans_resp};
  end

  assign drop_cnt     = drop_cnt_q;
  assign protocol_err = perr_q;

endmodule

// File: tb/tb_axi4_bch_drop_sender.sv
// Directed bench for axi4_bch_drop_sender: inputs change on the falling edge, outputs are
// checked 1 time unit later so the rising edge only ever sees settled stimulus.
module tb_axi4_bch_drop_sender;

  logic        clk = 1'b0;
  logic        arstn = 1'b0;
  logic        trans_valid, trans_drop, trans_ready;
  logic [9:0]  trans_id;
  logic [1:0]  trans_resp;
  logic        wvalid, wready, wlast;
  logic [9:0]  s_bid, m_bid;
  logic [1:0]  s_bresp, m_bresp;
  logic [3:0]  s_buser, m_buser;
  logic        s_bvalid, s_bready, m_bvalid, m_bready;
  logic [15:0] drop_cnt;
  logic        protocol_err;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  axi4_bch_drop_sender dut (
    .axi4_aclk(clk), .axi4_arstn(arstn),
    .trans_valid(trans_valid), .trans_drop(trans_drop), .trans_id(trans_id),
    .trans_resp(trans_resp), .trans_ready(trans_ready),
    .s_axi4_wvalid(wvalid), .s_axi4_wready(wready), .s_axi4_wlast(wlast),
    .s_axi4_bid(s_bid), .s_axi4_bresp(s_bresp), .s_axi4_buser(s_buser),
    .s_axi4_bvalid(s_bvalid), .s_axi4_bready(s_bready),
    .m_axi4_bid(m_bid), .m_axi4_bresp(m_bresp), .m_axi4_buser(m_buser),
    .m_axi4_bvalid(m_bvalid), .m_axi4_bready(m_bready),
    .drop_cnt(drop_cnt), .protocol_err(protocol_err)
  );

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    trans_valid = 0; trans_drop = 0; trans_id = '0; trans_resp = '0;
    wvalid = 0; wready = 0; wlast = 0;
    s_bready = 0; m_bvalid = 0; m_bid = '0; m_bresp = '0; m_buser = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    arstn = 0;
    idle_inputs();
    tick(); tick();
    arstn = 1;
    tick();
  endtask

  task automatic push_decision(input logic drop, input logic [9:0] id, input logic [1:0] resp);
    trans_valid = 1; trans_drop = drop; trans_id = id; trans_resp = resp;
    tick();
    trans_valid = 0; trans_drop = 0;
  endtask

  task automatic w_last_beat();
    wvalid = 1; wready = 1; wlast = 1;
    tick();
    wvalid = 0; wready = 0; wlast = 0;
  endtask

  task automatic test_reset();
    do_reset();
    m_bvalid = 1; s_bready = 1; m_bid = 10'h03A; m_bresp = 2'b11; m_buser = 4'h9;
    #1;
    checks++; if (s_bvalid !== 1'b1) begin errors++; $display("FAIL rst_bvalid_pass: got %0b exp 1", s_bvalid); end
    checks++; if (s_bid !== 10'h03A) begin errors++; $display("FAIL rst_bid_pass: got %0h exp 3a", s_bid); end
    checks++; if (s_buser !== 4'h9) begin errors++; $display("FAIL rst_buser_pass: got %0h exp 9", s_buser); end
    checks++; if (m_bready !== 1'b1) begin errors++; $display("FAIL rst_bready_pass: got %0b exp 1", m_bready); end
    checks++; if (trans_ready !== 1'b1) begin errors++; $display("FAIL rst_trans_ready: got %0b exp 1", trans_ready); end
    checks++; if (drop_cnt !== 16'd0) begin errors++; $display("FAIL rst_drop_cnt: got %0d exp 0", drop_cnt); end
    checks++; if (protocol_err !== 1'b0) begin errors++; $display("FAIL rst_perr: got %0b exp 0", protocol_err); end
    m_bvalid = 0; s_bready = 0;
    #1;
    checks++; if (s_bvalid !== 1'b0) begin errors++; $display("FAIL rst_bvalid_low: got %0b exp 0", s_bvalid); end
    checks++; if (m_bready !== 1'b0) begin errors++; $display("FAIL rst_bready_low: got %0b exp 0", m_bready); end
  endtask

  task automatic test_single_drop();
    do_reset();
    s_bready = 1;
    push_decision(1'b1, 10'h005, 2'b10);
    for (int i = 0; i < 4; i++) begin
      wvalid = 1; wready = 1; wlast = (i == 3);
      #1;
      checks++; if (s_bvalid !== 1'b0) begin errors++; $display("FAIL single_early_bvalid beat%0d: got %0b exp 0", i, s_bvalid); end
      tick();
    end
    wvalid = 0; wready = 0; wlast = 0;
    #1;
    checks++; if (s_bvalid !== 1'b1) begin errors++; $display("FAIL single_bvalid: got %0b exp 1", s_bvalid); end
    checks++; if (s_bid !== 10'h005) begin errors++; $display("FAIL single_bid: got %0h exp 5", s_bid); end
    checks++; if (s_bresp !== 2'b10) begin errors++; $display("FAIL single_bresp: got %0b exp 10", s_bresp); end
    checks++; if (s_buser !== 4'h0) begin errors++; $display("FAIL single_buser: got %0h exp 0", s_buser); end
    checks++; if (m_bready !== 1'b0) begin errors++; $display("FAIL single_m_bready: got %0b exp 0", m_bready); end
    tick();
    checks++; if (drop_cnt !== 16'd1) begin errors++; $display("FAIL single_drop_cnt: got %0d exp 1", drop_cnt); end
    checks++; if (s_bvalid !== 1'b0) begin errors++; $display("FAIL single_bvalid_after: got %0b exp 0", s_bvalid); end
  endtask

  task automatic test_interleave();
    do_reset();
    s_bready = 1;
    push_decision(1'b0, 10'h001, 2'b00);
    push_decision(1'b1, 10'h002, 2'b11);
    w_last_beat();
    #1;
    checks++; if (s_bvalid !== 1'b0) begin errors++; $display("FAIL ilv_no_inj_after_a: got %0b exp 0", s_bvalid); end
    wvalid = 1; wready = 1; wlast = 0;
    tick();
    wlast = 1;
    #1;
    checks++; if (s_bvalid !== 1'b0) begin errors++; $display("FAIL ilv_no_inj_mid_d: got %0b exp 0", s_bvalid); end
    tick();
    wvalid = 0; wready = 0; wlast = 0;
    #1;
    checks++; if (s_bvalid !== 1'b1) begin errors++; $display("FAIL ilv_inj_bvalid: got %0b exp 1", s_bvalid); end
    checks++; if (s_bid !== 10'h002) begin errors++; $display("FAIL ilv_inj_bid: got %0h exp 2", s_bid); end
    checks++; if (s_bresp !== 2'b11) begin errors++; $display("FAIL ilv_inj_bresp: got %0b exp 11", s_bresp); end
    tick();
    m_bvalid = 1; m_bid = 10'h001; m_bresp = 2'b00;
    #1;
    checks++; if (s_bid !== 10'h001) begin errors++; $display("FAIL ilv_fwd_bid: got %0h exp 1", s_bid); end
    checks++; if (m_bready !== 1'b1) begin errors++; $display("FAIL ilv_fwd_bready: got %0b exp 1", m_bready); end
    tick();
    m_bvalid = 0;
    checks++; if (drop_cnt !== 16'd1) begin errors++; $display("FAIL ilv_drop_cnt: got %0d exp 1", drop_cnt); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    push_decision(1'b1, 10'h021, 2'b01);
    push_decision(1'b1, 10'h022, 2'b10);
    m_bvalid = 1; m_bid = 10'h011; m_bresp = 2'b00; m_buser = 4'h5;
    w_last_beat();
    w_last_beat();
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (s_bid !== 10'h011 || s_buser !== 4'h5 || s_bvalid !== 1'b1) begin
        errors++; $display("FAIL b2b_stall%0d: got bid=%0h buser=%0h bvalid=%0b exp bid=11 buser=5 bvalid=1", i, s_bid, s_buser, s_bvalid);
      end
      tick();
    end
    s_bready = 1;
    #1;
    checks++; if (m_bready !== 1'b1 || s_bid !== 10'h011) begin errors++; $display("FAIL b2b_g1_master: got bready=%0b bid=%0h exp 1 11", m_bready, s_bid); end
    tick();
    m_bid = 10'h012;
    #1;
    checks++; if (m_bready !== 1'b0 || s_bid !== 10'h021 || s_bresp !== 2'b01) begin
      errors++; $display("FAIL b2b_g2_inject: got bready=%0b bid=%0h bresp=%0b exp 0 21 01", m_bready, s_bid, s_bresp);
    end
    tick();
    #1;
    checks++; if (m_bready !== 1'b1 || s_bid !== 10'h012) begin errors++; $display("FAIL b2b_g3_master: got bready=%0b bid=%0h exp 1 12", m_bready, s_bid); end
    tick();
    m_bvalid = 0;
    #1;
    checks++; if (s_bvalid !== 1'b1 || s_bid !== 10'h022 || s_bresp !== 2'b10) begin
      errors++; $display("FAIL b2b_g4_inject: got bvalid=%0b bid=%0h bresp=%0b exp 1 22 10", s_bvalid, s_bid, s_bresp);
    end
    tick();
    checks++; if (drop_cnt !== 16'd2) begin errors++; $display("FAIL b2b_drop_cnt: got %0d exp 2", drop_cnt); end
    checks++; if (s_bvalid !== 1'b0) begin errors++; $display("FAIL b2b_idle: got %0b exp 0", s_bvalid); end
  endtask

  task automatic test_full();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (trans_ready !== 1'b1) begin errors++; $display("FAIL full_ready_before%0d: got %0b exp 1", i, trans_ready); end
      push_decision(1'b1, 10'h031 + 10'(i), 2'b00);
    end
    #1;
    checks++; if (trans_ready !== 1'b0) begin errors++; $display("FAIL full_not_ready: got %0b exp 0", trans_ready); end
    w_last_beat();
    #1;
    checks++; if (s_bvalid !== 1'b1 || s_bid !== 10'h031) begin errors++; $display("FAIL full_inj: got bvalid=%0b bid=%0h exp 1 31", s_bvalid, s_bid); end
    checks++; if (trans_ready !== 1'b0) begin errors++; $display("FAIL full_still_full: got %0b exp 0", trans_ready); end
    s_bready = 1;
    tick();
    s_bready = 0;
    checks++; if (trans_ready !== 1'b1) begin errors++; $display("FAIL full_ready_after: got %0b exp 1", trans_ready); end
    checks++; if (drop_cnt !== 16'd1) begin errors++; $display("FAIL full_drop_cnt: got %0d exp 1", drop_cnt); end
  endtask

  task automatic test_bypass();
    do_reset();
    trans_valid = 1; trans_drop = 1; trans_id = 10'h155; trans_resp = 2'b01;
    wvalid = 1; wready = 1; wlast = 1;
    tick();
    idle_inputs();
    #1;
    checks++; if (protocol_err !== 1'b0) begin errors++; $display("FAIL byp_perr: got %0b exp 0", protocol_err); end
    checks++; if (s_bvalid !== 1'b1 || s_bid !== 10'h155 || s_bresp !== 2'b01) begin
      errors++; $display("FAIL byp_inj: got bvalid=%0b bid=%0h bresp=%0b exp 1 155 01", s_bvalid, s_bid, s_bresp);
    end
    s_bready = 1;
    tick();
    s_bready = 0;
    checks++; if (drop_cnt !== 16'd1) begin errors++; $display("FAIL byp_drop_cnt: got %0d exp 1", drop_cnt); end
    w_last_beat();
    checks++; if (protocol_err !== 1'b1) begin errors++; $display("FAIL perr_set: got %0b exp 1", protocol_err); end
    checks++; if (s_bvalid !== 1'b0) begin errors++; $display("FAIL perr_no_inj: got %0b exp 0", s_bvalid); end
    tick(); tick(); tick();
    checks++; if (protocol_err !== 1'b1) begin errors++; $display("FAIL perr_sticky: got %0b exp 1", protocol_err); end
  endtask

  task automatic test_reset_midop();
    do_reset();
    push_decision(1'b1, 10'h041, 2'b00);
    push_decision(1'b1, 10'h042, 2'b00);
    push_decision(1'b1, 10'h043, 2'b00);
    w_last_beat(); w_last_beat(); w_last_beat();
    s_bready = 1;
    tick();
    s_bready = 0;
    checks++; if (drop_cnt !== 16'd1 || s_bvalid !== 1'b1) begin
      errors++; $display("FAIL mid_pre: got drop_cnt=%0d bvalid=%0b exp 1 1", drop_cnt, s_bvalid);
    end
    arstn = 0;
    m_bvalid = 1; m_bid = 10'h077;
    #1;
    checks++; if (s_bvalid !== 1'b1 || s_bid !== 10'h077) begin errors++; $display("FAIL mid_pass: got bvalid=%0b bid=%0h exp 1 77", s_bvalid, s_bid); end
    checks++; if (drop_cnt !== 16'd0) begin errors++; $display("FAIL mid_drop_cnt: got %0d exp 0", drop_cnt); end
    m_bvalid = 0;
    #1;
    checks++; if (s_bvalid !== 1'b0) begin errors++; $display("FAIL mid_follow_low: got %0b exp 0", s_bvalid); end
    tick();
    arstn = 1;
    #1;
    checks++; if (trans_ready !== 1'b1) begin errors++; $display("FAIL mid_ready: got %0b exp 1", trans_ready); end
    tick();
    checks++; if (s_bvalid !== 1'b0) begin errors++; $display("FAIL mid_drops_lost: got %0b exp 0", s_bvalid); end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_single_drop();
    test_interleave();
    test_back_to_back();
    test_full();
    test_bypass();
    test_reset_midop();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
